// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
//   Shared types and helpers for the multi-channel LED pattern generator.
//   - led_mode_e : per-channel operating mode (2 bits, encoding matches i_mode)
//   - calc_div   : prescaler divide ratio from clock and tick rates
package led_pattern_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_BURST = 2'd3
  } led_mode_e;

  // Integer divide of the input clock down to the tick rate. A tick rate
  // above the clock rate (or a nonsensical zero) collapses to DIV=1, i.e. a
  // tick on every clock, rather than producing a zero-length counter.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0 || clk_hz < tick_hz) return 1;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// led_pattern_chan
//   One LED channel: holds mode/period/duty/phase/remaining and produces a
//   registered LED drive. Phase advances only on i_tick while in BLINK or
//   BURST; a write on the same edge as a tick takes priority and the tick is
//   dropped for this channel.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_tick             one-cycle prescaler pulse
//   i_wr               config write aimed at this channel
//   i_mode/i_period/i_duty/i_count  config fields latched on i_wr
//   o_led              registered LED drive
//   o_busy             high while a BURST is still running
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_tick,
  input  logic          i_wr,
  input  logic [1:0]    i_mode,
  input  logic [CW-1:0] i_period,
  input  logic [CW-1:0] i_duty,
  input  logic [BW-1:0] i_count,
  output logic          o_led,
  output logic          o_busy
);

  led_mode_e     mode_q,   mode_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] duty_q,   duty_d;
  logic [CW-1:0] phase_q,  phase_d;
  logic [BW-1:0] rem_q,    rem_d;
  logic          led_q,    led_d;
  logic          busy_q,   busy_d;

  logic [CW-1:0] p_last;
  logic [CW-1:0] phase_n;
  logic          wrap;
  led_mode_e     wr_mode;

  assign wr_mode = led_mode_e'(i_mode);

  // Period 0 behaves as period 1, so the last phase index is 0 in both cases.
  // Using >= rather than == keeps the counter bounded even if phase ever sits
  // beyond the last index.
  always_comb begin
    p_last  = (period_q == '0) ? '0 : period_q - CW'(1);
    wrap    = (phase_q >= p_last);
    phase_n = wrap ? '0 : phase_q + CW'(1);
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    led_d    = led_q;
    busy_d   = busy_q;

    if (i_wr) begin
      mode_d   = wr_mode;
      period_d = i_period;
      duty_d   = i_duty;
      phase_d  = '0;
      rem_d    = '0;
      busy_d   = 1'b0;
      case (wr_mode)
        LED_OFF:   led_d = 1'b0;
        LED_ON:    led_d = 1'b1;
        LED_BLINK: led_d = (i_duty != '0);
        LED_BURST: begin
          if (i_count == '0) begin
            // An empty burst is stored as plain OFF.
            mode_d = LED_OFF;
            led_d  = 1'b0;
          end else begin
            rem_d  = i_count;
            busy_d = 1'b1;
            led_d  = (i_duty != '0);
          end
        end
        default:   led_d = 1'b0;
      endcase
    end else if (i_tick && (mode_q == LED_BLINK || mode_q == LED_BURST)) begin
      phase_d = phase_n;
      led_d   = (phase_n < duty_q);
      if (mode_q == LED_BURST && wrap) begin
        rem_d = rem_q - BW'(1);
        // Last period done: LED, busy and mode all drop on this same edge.
        if (rem_q == BW'(1)) begin
          mode_d = LED_OFF;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      mode_q   <= LED_OFF;
      period_q <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      rem_q    <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED pattern generator. A shared prescaler divides i_clk to
//   TICK_HZ; each of NCHAN channels runs OFF / ON / BLINK / BURST from its own
//   latched config.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_wr, i_chan       one-cycle config write strobe and target channel
//   i_mode             0=OFF 1=ON 2=BLINK 3=BURST
//   i_period, i_duty   period and on-time in ticks (period 0 acts as 1)
//   i_count            burst length in periods
//   o_tick             one-cycle prescaler pulse
//   o_led, o_busy      per-channel registered LED drive / burst-active flag
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter  int CLOCK_RATE_HZ = 100_000_000,
  parameter  int TICK_HZ       = 1000,
  parameter  int NCHAN         = 4,
  parameter  int CW            = 16,
  parameter  int BW            = 8,
  localparam int CHW           = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wr,
  input  logic [CHW-1:0]   i_chan,
  input  logic [1:0]       i_mode,
  input  logic [CW-1:0]    i_period,
  input  logic [CW-1:0]    i_duty,
  input  logic [BW-1:0]    i_count,
  output logic             o_tick,
  output logic [NCHAN-1:0] o_led,
  output logic [NCHAN-1:0] o_busy
);

  localparam int DIV = calc_div(CLOCK_RATE_HZ, TICK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [PW-1:0]    presc_q;
  logic             tick_q;
  logic [NCHAN-1:0] wr_en;

  // Tick is registered: it is high for the cycle after the counter held
  // DIV-1. With DIV=1 the counter sits at 0 and the tick stays high.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else if (presc_q == DIV_LAST) begin
      presc_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      presc_q <= presc_q + PW'(1);
      tick_q  <= 1'b0;
    end
  end

  assign o_tick = tick_q;

  // Channels consume the registered tick, so LED edges land one clock after
  // the o_tick pulse. A channel index at or above NCHAN matches no decode
  // term and the write falls on the floor.
  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    assign wr_en[g] = i_wr && (i_chan == CHW'(g));

    led_pattern_chan #(
      .CW (CW),
      .BW (BW)
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_tick    (tick_q),
      .i_wr      (wr_en[g]),
      .i_mode    (i_mode),
      .i_period  (i_period),
      .i_duty    (i_duty),
      .i_count   (i_count),
      .o_led     (o_led[g]),
      .o_busy    (o_busy[g])
    );
  end

endmodule
